l2_port_arbiter: RTL
====================

// Module: l2_port_arbiter
// PURPOSE
//  Shares the single L1-side port of the L2 cache between two L1 requesters:
//  port 0 = I-cache, port 1 = D-cache. Grants round-robin and latches the
//  winner's address, operation and write block. Holds the L2 request until
//  the L2 signals ready, then returns the response to the winner only.
//  A watchdog aborts any transaction the L2 never completes.
// PARAMETERS
//  DATA_WIDTH      32  bits per word
//  ADDR_WIDTH      32  byte address width
//  BLOCK_SIZE      16  words per block; block buses are BLOCK_SIZE*DATA_WIDTH bits, flat
//  TIMEOUT_CYCLES  64  max BUSY cycles without l2_ready before abort; >=2
// PORTS
//  clk            in   1     single clock, rising edge
//  rst            in   1     synchronous, active-high reset
//  reqN_addr      in   AW    N=0,1: request address
//  reqN_wdata     in   BLK   write block
//  reqN_read      in   1     read request; level, held until reqN_ready
//  reqN_write     in   1     write request; level, held until reqN_ready
//  reqN_rdata     out  BLK   returned block; valid while reqN_valid=1
//  reqN_valid     out  1     block data valid (1-cycle pulse)
//  reqN_ready     out  1     transaction complete (1-cycle pulse)
//  reqN_hit       out  1     L2 reported hit
//  l2_addr        out  AW    to L2 l1_cache_addr
//  l2_wdata       out  BLK   to L2 l1_cache_data_in
//  l2_read        out  1     to L2 l1_cache_read
//  l2_write       out  1     to L2 l1_cache_write
//  l2_rdata       in   BLK   from L2 l1_block_data_out
//  l2_block_valid in   1     from L2 l1_block_valid
//  l2_ready       in   1     from L2 l1_cache_ready (combinational pulse)
//  l2_hit         in   1     from L2 l1_cache_hit
//  timeout_err    out  1     1-cycle pulse on watchdog abort
// BEHAVIOUR
//  - All outputs are registered. Reset forces state=IDLE, all outputs 0,
//    rr_ptr=0 (port 0 preferred), watchdog=0. Reset mid-transaction abandons
//    the transaction; the L2 must be reset on the same reset.
//  - reqN_read and reqN_write both high: treated as a read.
//  - FSM IDLE: if any port requests, grant it. Both request: grant port
//    rr_ptr. Latch grant, addr, wdata and op -> BUSY.
//    Latched l2_* drive from the next cycle.
//  - FSM BUSY: l2_read or l2_write held high with the latched values.
//    Requester inputs are ignored after grant. Watchdog increments each cycle.
//    * l2_ready=1: capture l2_rdata, l2_block_valid and l2_hit into the winner's
//      outputs. Drop l2_read/l2_write. -> DONE.
//    * watchdog==TIMEOUT_CYCLES-1 and no ready: drop l2_*. Arm winner ready=1,
//      valid=0, hit=0, plus timeout_err. -> DONE.
//  - FSM DONE (1 cycle): winner's reqN_ready/valid/hit/rdata visible; the
//    other port's outputs stay 0. rr_ptr <= ~grant. watchdog <= 0. -> IDLE.
//    Requester must drop its request at this edge.
//  - Latency on an L2 hit: request in cycle 0. l2_read high in cycles 1-2,
//    with L2 ready in cycle 2. reqN_ready in cycle 3. Next grant sampled in
//    cycle 4. Throughput is at most 1 transaction per 4 cycles.
//  - Misses stretch BUSY until l2_ready. A loser's request is held, never lost.
//    Starvation bound is 1 transaction.
//  - l2_read/l2_write are never high in IDLE or DONE, so the L2 always returns
//    to its idle state between grants.
// TESTING
//  1. req0 read addr 0x100, L2 hit: l2_read high in cycles 1-2 with
//     l2_addr=0x100. Cycle 3: req0_ready=req0_valid=req0_hit=1, rdata=L2 block;
//     all req1 outputs 0.
//  2. After reset, req0 (0x200) and req1 (0x300) rise in the same cycle:
//     l2_addr=0x200 first, then 0x300. req1_ready follows req0_ready by 4 cycles on hits.
//  3. Both ports requesting continuously for 4 transactions -> grant order
//     0,1,0,1. No port waits for more than 1 foreign transaction.
//  4. req1 write wdata=A. req1 changes wdata to B the cycle after grant:
//     l2_wdata=A and l2_write=1 throughout BUSY. req1_valid=0 if the L2 block_valid=0.
//  5. TIMEOUT_CYCLES=8 and l2_ready tied 0: l2_read high in cycles 1-8.
//     Cycle 9: timeout_err=1, req0_ready=1, req0_valid=0. Back in IDLE in cycle 10.
//  6. rst asserted in cycle 2 of a BUSY miss: next cycle all outputs 0 and
//     state IDLE. The first grant afterwards goes to port 0.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin share of the L2 L1-side port between I-cache (port 0) and D-cache (port 1).
// Latches the winner's request, holds it on the L2 until ready, and aborts transactions the L2 never finishes.
//  state | meaning
//  IDLE  | waiting for a request; grant and latch on the next edge
//  BUSY  | latched request driven on l2_*, watchdog running
//  DONE  | winner's response visible for one cycle, pointer rotates
module l2_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_WIDTH-1:0]              req0_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]   req0_wdata,
  input  logic                               req0_read,
  input  logic                               req0_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]   req0_rdata,
  output logic                               req0_valid,
  output logic                               req0_ready,
  output logic                               req0_hit,
  input  logic [ADDR_WIDTH-1:0]              req1_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]   req1_wdata,
  input  logic                               req1_read,
  input  logic                               req1_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]   req1_rdata,
  output logic                               req1_valid,
  output logic                               req1_ready,
  output logic                               req1_hit,
  output logic [ADDR_WIDTH-1:0]              l2_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]   l2_wdata,
  output logic                               l2_read,
  output logic                               l2_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]   l2_rdata,
  input  logic                               l2_block_valid,
  input  logic                               l2_ready,
  input  logic                               l2_hit,
  output logic                               timeout_err
);

  localparam int BLK_W = BLOCK_SIZE * DATA_WIDTH;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                     state_q, state_d;
  logic                       grant_q, grant_d;
  logic                       rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]            wd_q, wd_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [BLK_W-1:0]           wdata_q, wdata_d;
  logic                       rd_q, rd_d;
  logic                       wr_q, wr_d;
  logic [1:0][BLK_W-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                 rsp_valid_q, rsp_valid_d;
  logic [1:0]                 rsp_ready_q, rsp_ready_d;
  logic [1:0]                 rsp_hit_q, rsp_hit_d;
  logic                       tmo_q, tmo_d;
  logic [1:0]                 req_any;
  logic                       pick;

  assign req_any = {req1_read | req1_write, req0_read | req0_write};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      wd_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_ready_q <= '0;
      rsp_hit_q   <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_q        <= wd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_hit_q   <= rsp_hit_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    wd_d        = wd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_ready_d = rsp_ready_q;
    rsp_hit_d   = rsp_hit_q;
    tmo_d       = 1'b0;
    pick        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_any) begin
          pick    = (&req_any) ? rr_ptr_q : req_any[1];
          grant_d = pick;
          addr_d  = pick ? req1_addr  : req0_addr;
          wdata_d = pick ? req1_wdata : req0_wdata;
          // read wins when both op bits are set
          rd_d    = pick ? req1_read  : req0_read;
          wr_d    = pick ? (req1_write & ~req1_read) : (req0_write & ~req0_read);
          wd_d    = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (l2_ready) begin
          rd_d                 = 1'b0;
          wr_d                 = 1'b0;
          rsp_rdata_d[grant_q] = l2_rdata;
          rsp_valid_d[grant_q] = l2_block_valid;
          rsp_hit_d[grant_q]   = l2_hit;
          rsp_ready_d[grant_q] = 1'b1;
          state_d              = DONE;
        end else if (wd_q == WD_LAST) begin
          rd_d                 = 1'b0;
          wr_d                 = 1'b0;
          rsp_rdata_d[grant_q] = '0;
          rsp_valid_d[grant_q] = 1'b0;
          rsp_hit_d[grant_q]   = 1'b0;
          rsp_ready_d[grant_q] = 1'b1;
          tmo_d                = 1'b1;
          state_d              = DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      DONE: begin
        rsp_rdata_d = '0;
        rsp_valid_d = '0;
        rsp_ready_d = '0;
        rsp_hit_d   = '0;
        rr_ptr_d    = ~grant_q;
        wd_d        = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req0_rdata  = rsp_rdata_q[0];
  assign req0_valid  = rsp_valid_q[0];
  assign req0_ready  = rsp_ready_q[0];
  assign req0_hit    = rsp_hit_q[0];
  assign req1_rdata  = rsp_rdata_q[1];
  assign req1_valid  = rsp_valid_q[1];
  assign req1_ready  = rsp_ready_q[1];
  assign req1_hit    = rsp_hit_q[1];
  assign l2_addr     = addr_q;
  assign l2_wdata    = wdata_q;
  assign l2_read     = rd_q;
  assign l2_write    = wr_q;
  assign timeout_err = tmo_q;

endmodule
